// File: rtl/weight_stream_fifo.sv
// rtl/weight_stream_fifo.sv - parametrised DRAM-to-accelerator weight staging FIFO
// Circular buffer with separate occupancy register, optional first-word-fall-through read.
module weight_stream_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_req,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              do_push;
    logic              do_pop;
    logic              mem_we;
    logic [DATA_W-1:0] head;

    assign head = mem[rptr_q];

    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);

        // A pop frees the slot a write on a full FIFO needs in the same cycle.
        do_pop  = rd_req && !empty;
        do_push = wr_en && (!full || do_pop);

        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;

        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            mem_we = do_push;
            if (do_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d     = rptr_q + AW'(1);
                rd_data_d  = head;
                rd_valid_d = 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && !do_push) begin
                overflow_d = 1'b1;
            end
            if (rd_req && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= wr_data;
        end
    end

    // In FWFT mode an empty FIFO shows the last popped word so rd_data still resets to zero.
    assign rd_data   = (FWFT != 0 && !empty) ? head : rd_data_q;
    assign rd_valid  = (FWFT != 0) ? !empty : rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_weight_stream_fifo.sv
// tb/tb_weight_stream_fifo.sv - directed self-checking bench for weight_stream_fifo
module tb_weight_stream_fifo;
    logic        clk;
    logic        reset;
    logic        clr, wr_en, rd_req;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    logic        clr1, wr_en1, rd_req1;
    logic [15:0] wr_data1;
    logic [15:0] rd_data1;
    logic        rd_valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
    logic [4:0]  count1;

    int checks = 0;
    int errors = 0;

    weight_stream_fifo #(.DATA_W(16), .DEPTH(16), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    weight_stream_fifo #(.DATA_W(16), .DEPTH(16), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .clr(clr1), .wr_en(wr_en1), .wr_data(wr_data1),
        .rd_req(rd_req1), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
        .empty(empty1), .almost_full(almost_full1), .almost_empty(almost_empty1),
        .count(count1), .overflow(overflow1), .underflow(underflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        rd;
        logic        cl;
        logic [4:0]  cnt;
        logic        fu, em, af, ae, rv;
        logic [15:0] rdat;
        logic        ov, un;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(input logic wr, input logic [15:0] wd, input logic rd, input logic cl,
                                input logic [4:0] cnt, input logic fu, input logic em, input logic af,
                                input logic ae, input logic rv, input logic [15:0] rdat,
                                input logic ov, input logic un);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.cl = cl; v.cnt = cnt; v.fu = fu; v.em = em;
        v.af = af; v.ae = ae; v.rv = rv; v.rdat = rdat; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [4:0] cnt, input logic fu, input logic em,
                             input logic af, input logic ae, input logic rv, input logic [15:0] rdat,
                             input logic ov, input logic un);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(rdat));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    task automatic step(input logic wr, input logic [15:0] wd, input logic rd, input logic cl);
        wr_en = wr; wr_data = wd; rd_req = rd; clr = cl;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_req = 1'b0; clr = 1'b0;
    endtask

    task automatic step1(input logic wr, input logic [15:0] wd, input logic rd);
        wr_en1 = wr; wr_data1 = wd; rd_req1 = rd;
        @(posedge clk);
        #1;
        wr_en1 = 1'b0; rd_req1 = 1'b0;
    endtask

    initial begin
        clr = 0; wr_en = 0; rd_req = 0; wr_data = 0;
        clr1 = 0; wr_en1 = 0; rd_req1 = 0; wr_data1 = 0;

        for (int i = 0; i < 16; i++)
            vecs[i] = mk(1'b1, 16'(16'h0800 + i), 1'b0, 1'b0, 5'(i + 1), i == 15, 1'b0,
                         (i + 1) >= 14, (i + 1) <= 2, 1'b0, 16'h0000, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 16'h0810, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int j = 0; j < 16; j++)
            vecs[17 + j] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 5'(15 - j), 1'b0, j == 15,
                              (15 - j) >= 14, (15 - j) <= 2, 1'b1, 16'(16'h0800 + j), 1'b1, 1'b0);
        vecs[33] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h080F, 1'b1, 1'b1);
        vecs[34] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h080F, 1'b1, 1'b1);
        vecs[35] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h080F, 1'b0, 1'b0);

        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_state("reset", 5'd0, 0, 1, 0, 1, 0, 16'h0000, 0, 0);
        #18 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 36; k++) begin
            step(vecs[k].wr, vecs[k].wd, vecs[k].rd, vecs[k].cl);
            chk_state($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].fu, vecs[k].em, vecs[k].af,
                      vecs[k].ae, vecs[k].rv, vecs[k].rdat, vecs[k].ov, vecs[k].un);
        end

        for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0800 + i), 1'b0, 1'b0);
        chk("refill.count", 32'(count), 32'd16);
        step(1'b1, 16'h0900, 1'b1, 1'b0);
        chk_state("simul_full", 5'd16, 1, 0, 1, 0, 1, 16'h0800, 0, 0);
        for (int j = 1; j < 16; j++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            chk($sformatf("drain%0d.rd_data", j), 32'(rd_data), 32'(16'h0800 + j));
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk_state("drain_last", 5'd0, 0, 1, 0, 1, 1, 16'h0900, 0, 0);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk_state("simul_empty", 5'd1, 0, 0, 0, 1, 0, 16'h0900, 0, 1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("simul_empty_pop.rd_data", 32'(rd_data), 32'h1234);
        chk("simul_empty_pop.count", 32'(count), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        step(1'b1, 16'h0C00, 1'b0, 1'b0);
        step(1'b1, 16'h0C01, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 16'(16'h0C02 + k), 1'b0, 1'b0);
            chk($sformatf("wrap%0d.count_w", k), 32'(count), 32'd3);
            chk($sformatf("wrap%0d.ae_w", k), 32'(almost_empty), 32'd0);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            chk($sformatf("wrap%0d.count_r", k), 32'(count), 32'd2);
            chk($sformatf("wrap%0d.ae_r", k), 32'(almost_empty), 32'd1);
            chk($sformatf("wrap%0d.rd_valid", k), 32'(rd_valid), 32'd1);
            chk($sformatf("wrap%0d.rd_data", k), 32'(rd_data), 32'(16'h0C00 + k));
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0D00 + i), 1'b0, 1'b0);
        chk("flush_pre.count", 32'(count), 32'd5);
        step(1'b1, 16'h0DFF, 1'b0, 1'b1);
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.empty", 32'(empty), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("flush_idle.count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0E00 + i), 1'b0, 1'b0);
        chk("refill3.count", 32'(count), 32'd3);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("refill3_pop.rd_data", 32'(rd_data), 32'h0E00);
        #2 reset = 1'b0;
        #1 chk_state("async_reset", 5'd0, 0, 1, 0, 1, 0, 16'h0000, 0, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_reset", 5'd0, 0, 1, 0, 1, 0, 16'h0000, 0, 0);

        chk("fwft_idle.rd_valid", 32'(rd_valid1), 32'd0);
        chk("fwft_idle.rd_data", 32'(rd_data1), 32'h0000);
        step1(1'b1, 16'h0A01, 1'b0);
        chk("fwft_wr.rd_valid", 32'(rd_valid1), 32'd1);
        chk("fwft_wr.rd_data", 32'(rd_data1), 32'h0A01);
        step1(1'b0, 16'h0000, 1'b0);
        chk("fwft_hold.rd_data", 32'(rd_data1), 32'h0A01);
        step1(1'b0, 16'h0000, 1'b1);
        chk("fwft_pop.rd_valid", 32'(rd_valid1), 32'd0);
        chk("fwft_pop.empty", 32'(empty1), 32'd1);
        step1(1'b1, 16'h0A02, 1'b0);
        step1(1'b1, 16'h0A03, 1'b0);
        chk("fwft_two.rd_data", 32'(rd_data1), 32'h0A02);
        step1(1'b0, 16'h0000, 1'b1);
        chk("fwft_next.rd_valid", 32'(rd_valid1), 32'd1);
        chk("fwft_next.rd_data", 32'(rd_data1), 32'h0A03);
        chk("fwft_next.count", 32'(count1), 32'd1);
        step1(1'b0, 16'h0000, 1'b1);
        step1(1'b0, 16'h0000, 1'b1);
        chk("fwft_under.underflow", 32'(underflow1), 32'd1);
        chk("fwft_under.rd_valid", 32'(rd_valid1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_stream_fifo.md
Name: weight_stream_fifo

Overview:
Parametrised successor to the single-depth DRAM staging fifo that feeds the Accelerator's DRAMdata input. It buffers weight/input words written from the DRAM side (write strobe qualified by DVAL-style valid) and returns them to the Accelerator on SRAM_RdReq-style read requests. New behaviour over the previous fifo:
- Configurable width and depth.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Occupancy count, almost-full/almost-empty flags, sticky overflow/underflow flags.
- Synchronous flush.

Parameters:
DATA_W, 16, word width in bits.
DEPTH, 16, number of entries; power of two, >= 4.
FWFT, 0, 0 = registered read with 1-cycle latency; 1 = head word presented combinationally while not empty.
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH.
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
clr  in  1  synchronous flush.
wr_en  in  1  write strobe.
wr_data  in  DATA_W  write word.
rd_req  in  1  read/pop request.
rd_data  out  DATA_W  read word.
rd_valid  out  1  rd_data qualifier.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AFULL_TH.
almost_empty  out  1  count <= AEMPTY_TH.
count  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Flags: empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Storage: circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH. count is held in a separate register. Flags are decoded combinationally from count.
- Write: wr_en && !full stores wr_data at wptr, then wptr+1.
- Write while full: wr_en && full drops the word and sets overflow, except in the simultaneous-pop case below.
- Read, FWFT=0: rd_req && !empty pops the entry at rptr. rd_data is registered and appears the next cycle with rd_valid=1 for exactly 1 cycle. Otherwise rd_valid=0 and rd_data holds its last value.
- Read, FWFT=1: rd_data = mem[rptr] and rd_valid = !empty, both combinational. rd_req && !empty advances rptr; the next word is visible in the following cycle.
- Read while empty: rd_req && empty pops nothing and sets underflow. rd_valid stays 0.
- Simultaneous wr_en and rd_req:
  - not full and not empty: both occur, count unchanged.
  - full: pop and write both occur, count stays DEPTH, no overflow.
  - empty: write occurs, read is an underflow (sets underflow, count becomes 1). Write-to-read bypass is not supported.
- clr=1: next edge sets pointers=0, count=0, rd_valid=0, overflow=0, underflow=0. clr has priority over wr_en/rd_req in the same cycle. rd_data holds its value.
- overflow and underflow are cleared only by reset or clr.
- count never exceeds DEPTH and never goes below 0.

Test Plan:
- Fill/order (FWFT=0, DEPTH=16): write 0x0800..0x080F on 16 consecutive cycles.
  -> almost_full rises after the 14th write; full=1 and count=16 after the 16th.
  -> Then rd_req for 16 cycles: rd_data = 0x0800..0x080F, each 1 cycle after its request, rd_valid high 16 cycles. empty=1 after the last pop.
- Overflow/underflow: on a full FIFO, write 0x0810.
  -> overflow=1, count stays 16; drain returns 0x080F as the last word.
  -> rd_req on empty: underflow=1, rd_valid=0. Both flags stay set until clr.
- Simultaneous access: full FIFO, wr_en with 0x0900 and rd_req together.
  -> count=16, no overflow; 0x0900 emerges after 0x080F.
  -> Empty FIFO with both asserted: count=1, underflow=1.
- Pointer wrap: cycle 40 writes and 40 reads interleaved, keeping count between 1 and 3.
  -> Output sequence exactly matches the input sequence; almost_empty tracks count<=2.
- FWFT=1: write 0x0A01.
  -> Next cycle rd_valid=1 and rd_data=0x0A01 with no request; rd_req pops and rd_valid drops.
- Flush/reset mid-operation: with count=5, assert clr together with wr_en.
  -> count=0, empty=1, write ignored.
  -> Refill to 3, pulse reset low for 2 ns between edges: all outputs return to reset values immediately.
